// File: rtl/aes_axi_stream_slave.sv
// AXI4-Stream slave: captures a command word, packs 4x32-bit words into 128-bit blocks for the AES input FIFO.
// Optional build macro AES_SLAVE_BYTE_SWAP_EN byte-reverses each data word before packing.
module aes_axi_stream_slave #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DATA_WIDTH      = 128,
    parameter int WORD_CNT_WIDTH       = 2
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_areset,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                              s00_axis_tlast,
    output logic [FIFO_DATA_WIDTH-1:0]        in_fifo_data,
    output logic                              in_fifo_write_tvalid,
    input  logic                              in_fifo_write_tready,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   aes_cmd,
    output logic                              aes_cmd_valid,
    output logic                              axis_slave_done,
    output logic                              blk_short_err
);

    localparam logic [WORD_CNT_WIDTH-1:0] LAST_WORD =
        WORD_CNT_WIDTH'(FIFO_DATA_WIDTH / C_S_AXIS_TDATA_WIDTH - 1);

    typedef enum logic [1:0] {S_CMD, S_COLLECT, S_PUSH} state_t;

    state_t                            r_state;
    state_t                            w_next;
    logic [WORD_CNT_WIDTH-1:0]         r_word_cnt;
    logic [FIFO_DATA_WIDTH-1:0]        r_blk;
    logic                              r_blk_last;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]   r_cmd;
    logic                              r_cmd_valid;
    logic                              r_done;
    logic                              r_short_err;

    logic                              w_hs;
    logic                              w_blk_end;
    logic                              w_bad_strb;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]   w_word;

    assign s00_axis_tready      = (r_state != S_PUSH);
    assign in_fifo_write_tvalid = (r_state == S_PUSH);
    assign in_fifo_data         = r_blk;
    assign aes_cmd              = r_cmd;
    assign aes_cmd_valid        = r_cmd_valid;
    assign axis_slave_done      = r_done;
    assign blk_short_err        = r_short_err;

    assign w_hs       = s00_axis_tvalid && s00_axis_tready;
    assign w_blk_end  = (r_word_cnt == LAST_WORD) || s00_axis_tlast;
    assign w_bad_strb = (s00_axis_tstrb != '1);

`ifdef AES_SLAVE_BYTE_SWAP_EN
    assign w_word = {s00_axis_tdata[7:0], s00_axis_tdata[15:8],
                     s00_axis_tdata[23:16], s00_axis_tdata[31:24]};
`else
    assign w_word = s00_axis_tdata;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CMD:     if (w_hs && !s00_axis_tlast) w_next = S_COLLECT;
            S_COLLECT: if (w_hs && w_blk_end)       w_next = S_PUSH;
            S_PUSH:    if (in_fifo_write_tready)    w_next = r_blk_last ? S_CMD : S_COLLECT;
            default:                                w_next = S_CMD;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) r_state <= S_CMD;
        else                 r_state <= w_next;
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            r_word_cnt  <= '0;
            r_blk       <= '0;
            r_blk_last  <= 1'b0;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_done      <= 1'b0;
            r_short_err <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_CMD: begin
                    if (w_hs) begin
                        r_cmd       <= s00_axis_tdata;
                        r_cmd_valid <= 1'b1;
                        r_short_err <= w_bad_strb;
                        r_word_cnt  <= '0;
                        r_blk       <= '0;
                        r_done      <= s00_axis_tlast;
                    end
                end
                S_COLLECT: begin
                    if (w_hs) begin
                        r_blk[C_S_AXIS_TDATA_WIDTH*r_word_cnt +: C_S_AXIS_TDATA_WIDTH] <= w_word;
                        r_word_cnt <= r_word_cnt + WORD_CNT_WIDTH'(1);
                        if (w_blk_end) r_blk_last <= s00_axis_tlast;
                        // Short final block keeps its zeroed upper slots; only the flag records it.
                        if (w_bad_strb || (s00_axis_tlast && r_word_cnt != LAST_WORD))
                            r_short_err <= 1'b1;
                    end
                end
                S_PUSH: begin
                    if (in_fifo_write_tready) begin
                        r_word_cnt <= '0;
                        r_blk      <= '0;
                        r_done     <= r_blk_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_axi_stream_slave.sv
// Self-checking bench for aes_axi_stream_slave: directed and random packets against a block-packing reference model.
module tb_aes_axi_stream_slave;

    logic         clk = 1'b0;
    logic         rst;
    logic         s00_axis_tvalid;
    logic         s00_axis_tready;
    logic [31:0]  s00_axis_tdata;
    logic [3:0]   s00_axis_tstrb;
    logic         s00_axis_tlast;
    logic [127:0] in_fifo_data;
    logic         in_fifo_write_tvalid;
    logic         in_fifo_write_tready;
    logic [31:0]  aes_cmd;
    logic         aes_cmd_valid;
    logic         axis_slave_done;
    logic         blk_short_err;

    always #5 clk = ~clk;

    aes_axi_stream_slave #(
        .C_S_AXIS_TDATA_WIDTH(32),
        .FIFO_DATA_WIDTH(128),
        .WORD_CNT_WIDTH(2)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_areset(rst),
        .s00_axis_tvalid(s00_axis_tvalid),
        .s00_axis_tready(s00_axis_tready),
        .s00_axis_tdata(s00_axis_tdata),
        .s00_axis_tstrb(s00_axis_tstrb),
        .s00_axis_tlast(s00_axis_tlast),
        .in_fifo_data(in_fifo_data),
        .in_fifo_write_tvalid(in_fifo_write_tvalid),
        .in_fifo_write_tready(in_fifo_write_tready),
        .aes_cmd(aes_cmd),
        .aes_cmd_valid(aes_cmd_valid),
        .axis_slave_done(axis_slave_done),
        .blk_short_err(blk_short_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] mon_q[$];
    int           done_cnt  = 0;
    int           cmdv_cnt  = 0;
    int           done_blks = -1;
    int           stall_at  = -1;
    int           stall_left = 0;
    bit           rand_bp   = 1'b0;

    logic [31:0]  data_q[$];
    logic [3:0]   strb_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] w);
`ifdef AES_SLAVE_BYTE_SWAP_EN
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
        return r;
`else
        return w;
`endif
    endfunction

    // Output-side monitor, sampled on the falling edge.
    initial begin
        logic [127:0] held;
        bit           held_v;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
            end else begin
                if (in_fifo_write_tvalid) begin
                    chk("tready_low_in_push", s00_axis_tready, 1'b0);
                    if (held_v) chk("blk_stable", in_fifo_data, held);
                    if (in_fifo_write_tready) begin
                        mon_q.push_back(in_fifo_data);
                        held_v = 1'b0;
                    end else begin
                        held   = in_fifo_data;
                        held_v = 1'b1;
                    end
                end
                if (axis_slave_done) begin
                    done_cnt++;
                    done_blks = mon_q.size();
                end
                if (aes_cmd_valid) cmdv_cnt++;
            end
        end
    end

    // FIFO-ready driver: directed stall window or random backpressure.
    initial begin
        in_fifo_write_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && in_fifo_write_tvalid && mon_q.size() == stall_at) begin
                in_fifo_write_tready = 1'b0;
                stall_left--;
            end else if (rand_bp) begin
                in_fifo_write_tready = ($urandom_range(0, 2) != 0);
            end else begin
                in_fifo_write_tready = 1'b1;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_word(input logic [31:0] d, input logic [3:0] s, input bit last, output int waits);
        s00_axis_tvalid = 1'b1;
        s00_axis_tdata  = d;
        s00_axis_tstrb  = s;
        s00_axis_tlast  = last;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!s00_axis_tready && waits < 200);
        chk("hs_timeout", s00_axis_tready, 1'b1);
        @(posedge clk);
        #1;
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
    endtask

    task automatic run_packet(input logic [31:0] cmd, input bit gaps, input bit chk_thru);
        int n, w, k, nb;
        bit exp_err;
        logic [127:0] exp_blk;
        n = data_q.size();
        mon_q.delete();
        done_cnt  = 0;
        cmdv_cnt  = 0;
        done_blks = -1;
        send_word(cmd, 4'hF, (n == 0), w);
        for (int i = 0; i < n; i++) begin
            bit gap;
            gap = gaps && ($urandom_range(0, 2) == 0);
            if (gap) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            send_word(data_q[i], strb_q[i], (i == n - 1), w);
            if (chk_thru && !gap && i % 4 == 0 && i > 0) chk("thru_gap", w, 2);
            if (i % 4 == 3 || i == n - 1) chk("push_latency", in_fifo_write_tvalid, 1'b1);
        end
        k = 0;
        while (done_cnt == 0 && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (3) @(posedge clk);
        #1;

        nb = (n + 3) / 4;
        exp_err = (n % 4 != 0);
        foreach (strb_q[i]) if (strb_q[i] != 4'hF) exp_err = 1'b1;
        chk("blk_count", mon_q.size(), nb);
        for (int b = 0; b < nb; b++) begin
            exp_blk = '0;
            for (int j = 0; j < 4; j++)
                if (4 * b + j < n) exp_blk = exp_blk | (128'(model_word(data_q[4*b+j])) << (32 * j));
            chk("blk_data", (b < mon_q.size()) ? mon_q[b] : 128'hx, exp_blk);
        end
        chk("aes_cmd", aes_cmd, cmd);
        chk("cmd_valid_pulses", cmdv_cnt, 1);
        chk("done_pulses", done_cnt, 1);
        chk("done_after_last_blk", done_blks, nb);
        chk("short_err", blk_short_err, exp_err);
    endtask

    task automatic fill_seq(input int n, input logic [31:0] base);
        data_q.delete();
        strb_q.delete();
        for (int i = 0; i < n; i++) begin
            data_q.push_back(base + 32'(i));
            strb_q.push_back(4'hF);
        end
    endtask

    initial begin
        int w;
        rst             = 1'b1;
        s00_axis_tvalid = 1'b0;
        s00_axis_tdata  = '0;
        s00_axis_tstrb  = 4'hF;
        s00_axis_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tready", s00_axis_tready, 1'b1);
        chk("rst_fifo_valid", in_fifo_write_tvalid, 1'b0);
        chk("rst_fifo_data", in_fifo_data, '0);
        chk("rst_cmd", aes_cmd, '0);
        chk("rst_cmd_valid", aes_cmd_valid, 1'b0);
        chk("rst_done", axis_slave_done, 1'b0);
        chk("rst_err", blk_short_err, 1'b0);
        @(posedge clk);
        #1;

        // One full block.
        fill_seq(4, 32'h1);
        run_packet(32'h0000_0010, 1'b0, 1'b0);

        // Three blocks with the FIFO stalled for 10 cycles on block 2.
        data_q.delete();
        strb_q.delete();
        for (int i = 0; i < 12; i++) begin
            data_q.push_back($urandom);
            strb_q.push_back(4'hF);
        end
        stall_at   = 1;
        stall_left = 10;
        run_packet($urandom, 1'b0, 1'b0);
        chk("stall_consumed", stall_left, 0);
        stall_at = -1;

        // Short final block: w6_w5 zero padded, error set.
        fill_seq(6, 32'hA000_0001);
        run_packet(32'h0000_0020, 1'b0, 1'b1);
        chk("short_err_set", blk_short_err, 1'b1);

        // Next command clears the error.
        fill_seq(4, 32'hB000_0000);
        run_packet(32'h0000_0030, 1'b0, 1'b1);

        // Command-only packet.
        data_q.delete();
        strb_q.delete();
        run_packet(32'hDEAD_BEEF, 1'b0, 1'b0);

        // Bad strobe on a full packet: data unmodified, error set.
        fill_seq(8, 32'hC000_0000);
        strb_q[5] = 4'h3;
        run_packet(32'h0000_0040, 1'b0, 1'b1);

        // Byte-order probe word (swapped only in the swap build).
        data_q.delete();
        strb_q.delete();
        data_q.push_back(32'h1122_3344);
        data_q.push_back(32'h5566_7788);
        data_q.push_back(32'h99AA_BBCC);
        data_q.push_back(32'hDDEE_FF00);
        repeat (4) strb_q.push_back(4'hF);
        run_packet(32'h1122_3344, 1'b0, 1'b0);

        // Asynchronous reset after word 2 of a block, then a fresh packet.
        send_word(32'h0000_0050, 4'hF, 1'b0, w);
        send_word(32'hEEEE_0001, 4'hF, 1'b0, w);
        send_word(32'hEEEE_0002, 4'hF, 1'b0, w);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tready", s00_axis_tready, 1'b1);
        chk("arst_fifo_valid", in_fifo_write_tvalid, 1'b0);
        chk("arst_fifo_data", in_fifo_data, '0);
        chk("arst_cmd", aes_cmd, '0);
        chk("arst_cmd_valid", aes_cmd_valid, 1'b0);
        chk("arst_done", axis_slave_done, 1'b0);
        chk("arst_err", blk_short_err, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        fill_seq(4, 32'h7000_0000);
        run_packet(32'h0000_0060, 1'b0, 1'b0);

        // Random packets with idle gaps and random FIFO backpressure.
        rand_bp = 1'b1;
        for (int p = 0; p < 6; p++) begin
            int n;
            n = $urandom_range(0, 13);
            data_q.delete();
            strb_q.delete();
            for (int i = 0; i < n; i++) begin
                data_q.push_back($urandom);
                strb_q.push_back(($urandom_range(0, 7) == 0) ? 4'hE : 4'hF);
            end
            run_packet($urandom, 1'b1, 1'b0);
        end
        rand_bp = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
